// File: rtl/aib_sl_sr_tx.sv
`default_nettype none
// ============================================================================
// Module   : aib_sl_sr_tx
// Purpose  : Slave-side sideband shift-chain transmitter. Serializes the
//            slave status bits into a framed stream (data MSB first, then a
//            one-cycle load strobe), one frame every SrLen+1 aux clocks.
// Option   : AIB_SL_SR_SYNC_EN - 2-flop synchronizers on the status inputs.
// Revision : 1.0 - initial release
// ============================================================================
module aib_sl_sr_tx #(
  parameter int   SrLen     = 72,
  parameter int   OscIdx    = 0,
  parameter int   RxXferIdx = 1,
  parameter int   RxDllIdx  = 2,
  parameter int   TxXferIdx = 3,
  parameter int   TxDcdIdx  = 4,
  parameter logic UnusedVal = 1'b1
) (
  input  logic        i_aux_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        c_sl_osc_transfer_en,
  input  logic        c_sl_rx_transfer_en,
  input  logic        c_sl_rx_dll_lock,
  input  logic        c_sl_tx_transfer_en,
  input  logic        c_sl_tx_dcd_cal_done,
  output logic        o_sr_data,
  output logic        o_sr_load,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt
);

  localparam int             CW       = $clog2(SrLen + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SrLen - 1);

  // Bad bit map or a chain too short to shift is an elaboration error.
  if (SrLen < 2 ||
      OscIdx < 0 || RxXferIdx < 0 || RxDllIdx < 0 || TxXferIdx < 0 || TxDcdIdx < 0 ||
      OscIdx >= SrLen || RxXferIdx >= SrLen || RxDllIdx >= SrLen ||
      TxXferIdx >= SrLen || TxDcdIdx >= SrLen ||
      OscIdx == RxXferIdx || OscIdx == RxDllIdx || OscIdx == TxXferIdx ||
      OscIdx == TxDcdIdx || RxXferIdx == RxDllIdx || RxXferIdx == TxXferIdx ||
      RxXferIdx == TxDcdIdx || RxDllIdx == TxXferIdx || RxDllIdx == TxDcdIdx ||
      TxXferIdx == TxDcdIdx) begin : g_bad_params
    $fatal(1, "aib_sl_sr_tx: chain index out of range or duplicated");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Status bits packed as {tx_dcd, tx_xfer, rx_dll, rx_xfer, osc}
  logic [4:0] stat_raw;
  logic [4:0] stat;
  assign stat_raw = {c_sl_tx_dcd_cal_done, c_sl_tx_transfer_en, c_sl_rx_dll_lock,
                     c_sl_rx_transfer_en, c_sl_osc_transfer_en};

`ifdef AIB_SL_SR_SYNC_EN
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  // Two-stage synchronizer for the asynchronous status inputs
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 5'd0;
      sync2_q <= 5'd0;
    end else begin
      sync1_q <= stat_raw;
      sync2_q <= sync1_q;
    end
  end
  assign stat = sync2_q;
`else
  assign stat = stat_raw;
`endif

  logic [SrLen-1:0] cap;

  // Build the frame image: mapped positions carry status, the rest UnusedVal
  always_comb begin
    cap            = {SrLen{UnusedVal}};
    cap[OscIdx]    = stat[0];
    cap[RxXferIdx] = stat[1];
    cap[RxDllIdx]  = stat[2];
    cap[TxXferIdx] = stat[3];
    cap[TxDcdIdx]  = stat[4];
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Snapshot is held as a left-shifting register: its MSB is always the next
  // bit to send, so the captured image is consumed as the frame goes out.
  logic [SrLen-1:0] snap_q, snap_d;
  logic             data_q, data_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  // Next-state and registered-output computation for the frame sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    snap_d      = snap_q;
    data_d      = 1'b0;
    load_d      = 1'b0;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (i_en) begin
          // Capture and present the first (MSB) bit on the same edge
          state_d = ST_SHIFT;
          cnt_d   = '0;
          snap_d  = {cap[SrLen-2:0], 1'b0};
          data_d  = cap[SrLen-1];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_LOAD;
          load_d      = 1'b1;
          done_d      = 1'b1;
          frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          data_d = snap_q[SrLen-1];
          snap_d = {snap_q[SrLen-2:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge i_aux_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      snap_q      <= '0;
      data_q      <= 1'b0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      data_q      <= data_d;
      load_q      <= load_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_sr_data    = data_q;
  assign o_sr_load    = load_q;
  assign o_frame_done = done_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aib_sl_sr_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_aib_sl_sr_tx
// Purpose  : Directed self-checking bench for aib_sl_sr_tx (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aib_sl_sr_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        osc, rxx, rxd, txx, txd;
  logic        sr_data, sr_load, frame_done;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Frame images (72 bits, bit 71 first). All ones except listed zeros.
  localparam logic [71:0] W_BASE   = 72'hFFFF_FFFF_FFFF_FFFF_ED; // bits 1,4 = 0
  localparam logic [71:0] W_DLL0   = 72'hFFFF_FFFF_FFFF_FFFF_E9; // bits 1,2,4 = 0
  localparam logic [71:0] W_TXX0   = 72'hFFFF_FFFF_FFFF_FFFF_E5; // bits 1,3,4 = 0
`ifdef AIB_SL_SR_SYNC_EN
  // Synchronizers come out of reset at 0, so the first capture sees all zeros
  localparam logic [71:0] W_FIRST  = 72'hFFFF_FFFF_FFFF_FFFF_E0;
  localparam logic [71:0] W_LATE   = W_BASE;
`else
  localparam logic [71:0] W_FIRST  = W_BASE;
  localparam logic [71:0] W_LATE   = W_TXX0;
`endif

  always #5 clk = ~clk;

  aib_sl_sr_tx dut (
    .i_aux_clk            (clk),
    .i_rst_n              (rst_n),
    .i_en                 (en),
    .c_sl_osc_transfer_en (osc),
    .c_sl_rx_transfer_en  (rxx),
    .c_sl_rx_dll_lock     (rxd),
    .c_sl_tx_transfer_en  (txx),
    .c_sl_tx_dcd_cal_done (txd),
    .o_sr_data            (sr_data),
    .o_sr_load            (sr_load),
    .o_frame_done         (frame_done),
    .o_frame_cnt          (frame_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the first data-bit cycle; gathers bits until the load cycle.
  // act: 1 rx_dll=1, 2 en=0, 3 tx_xfer=0, 4 rx_dll=0 (applied at cycle act_k)
  task automatic collect(input int act_k, input int act,
                         output logic [71:0] w, output int n, output bit got_load);
    w = '0;
    n = 0;
    got_load = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (sr_load) begin
        got_load = 1'b1;
        break;
      end
      w = {w[70:0], sr_data};
      n++;
      if (c == act_k) begin
        case (act)
          1: rxd = 1'b1;
          2: en  = 1'b0;
          3: txx = 1'b0;
          4: rxd = 1'b0;
          default: ;
        endcase
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    osc = 1'b1; rxx = 1'b0; rxd = 1'b1; txx = 1'b1; txd = 1'b0;
    step(); step(); step();
    checks++; if (sr_data !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", sr_data); end
    checks++; if (sr_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", sr_load); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h want 0000", frame_cnt); end
  endtask

  task automatic test_first_frame();
    logic [71:0] w; int n; bit gl;
    en = 1'b1;
    rst_n = 1'b1;
    step();
    collect(-1, 0, w, n, gl);
    checks++; if (!gl) begin errors++; $display("FAIL first_load_seen got 0 want 1"); end
    checks++; if (n !== 72) begin errors++; $display("FAIL first_bits got %0d want 72", n); end
    checks++; if (w !== W_FIRST) begin errors++; $display("FAIL first_word got %h want %h", w, W_FIRST); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL first_done got %b want 1", frame_done); end
    checks++; if (sr_data !== 1'b0) begin errors++; $display("FAIL first_load_data got %b want 0", sr_data); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL first_cnt got %0d want 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [71:0] w; int n; bit gl;
    for (int f = 2; f <= 10; f++) begin
      step();
      // Last frame pre-clears rx_dll_lock well ahead of the next capture
      collect((f == 10) ? 60 : -1, 4, w, n, gl);
      checks++; if (!gl || n !== 72) begin errors++; $display("FAIL b2b_period frame %0d got %0d bits load %b want 72 1", f, n, gl); end
      checks++; if (w !== W_BASE) begin errors++; $display("FAIL b2b_word frame %0d got %h want %h", f, w, W_BASE); end
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done frame %0d got %b want 1", f, frame_done); end
      checks++; if (frame_cnt !== 16'(f)) begin errors++; $display("FAIL b2b_cnt got %0d want %0d", frame_cnt, f); end
    end
  endtask

  task automatic test_status_change();
    logic [71:0] w; int n; bit gl;
    step();
    collect(30, 1, w, n, gl);
    checks++; if (!gl || w !== W_DLL0) begin errors++; $display("FAIL chg_cur_word got %h load %b want %h 1", w, gl, W_DLL0); end
    step();
    collect(-1, 0, w, n, gl);
    checks++; if (!gl || w !== W_BASE) begin errors++; $display("FAIL chg_next_word got %h load %b want %h 1", w, gl, W_BASE); end
    checks++; if (frame_cnt !== 16'd12) begin errors++; $display("FAIL chg_cnt got %0d want 12", frame_cnt); end
  endtask

  task automatic test_drop_en();
    logic [71:0] w; int n; bit gl; bit bad;
    step();
    collect(10, 2, w, n, gl);
    checks++; if (!gl || n !== 72) begin errors++; $display("FAIL drop_bits got %0d load %b want 72 1", n, gl); end
    checks++; if (w !== W_BASE) begin errors++; $display("FAIL drop_word got %h want %h", w, W_BASE); end
    checks++; if (frame_cnt !== 16'd13) begin errors++; $display("FAIL drop_cnt got %0d want 13", frame_cnt); end
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sr_data !== 1'b0 || sr_load !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL drop_idle got activity want data=0 load=0"); end
  endtask

  task automatic test_reset_mid();
    logic [71:0] w; int n; bit gl;
    en = 1'b1;
    step();
    for (int k = 0; k < 40; k++) step();
    rst_n = 1'b0;
    #1;
    checks++; if (frame_cnt !== 16'd0 || sr_load !== 1'b0 || sr_data !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got cnt %0d load %b data %b want 0 0 0", frame_cnt, sr_load, sr_data); end
    step(); step();
    rst_n = 1'b1;
    step();
    collect(-1, 0, w, n, gl);
    checks++; if (!gl || n !== 72) begin errors++; $display("FAIL rstmid_bits got %0d load %b want 72 1", n, gl); end
    checks++; if (w !== W_FIRST) begin errors++; $display("FAIL rstmid_word got %h want %h", w, W_FIRST); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_cnt got %0d want 1", frame_cnt); end
    en = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    logic [71:0] w; int n; bit gl;
    force dut.frame_cnt_q = 16'hFFFE;
    step();
    release dut.frame_cnt_q;
    step();
    checks++; if (frame_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h want fffe", frame_cnt); end
    en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      step();
      collect(-1, 0, w, n, gl);
      checks++; if (!gl || frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt frame %0d got %h load %b want ffff 1", f, frame_cnt, gl); end
    end
  endtask

  task automatic test_status_latency();
    logic [71:0] w; int n; bit gl;
    step();
    collect(71, 3, w, n, gl);
    checks++; if (!gl || w !== W_BASE) begin errors++; $display("FAIL lat_cur_word got %h want %h", w, W_BASE); end
    step();
    collect(-1, 0, w, n, gl);
    checks++; if (!gl || w !== W_LATE) begin errors++; $display("FAIL lat_next_word got %h want %h", w, W_LATE); end
    step();
    collect(-1, 0, w, n, gl);
    checks++; if (!gl || w !== W_TXX0) begin errors++; $display("FAIL lat_after_word got %h want %h", w, W_TXX0); end
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL lat_cnt got %h want ffff", frame_cnt); end
    en = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_status_change();
    test_drop_en();
    test_reset_mid();
    test_saturation();
    test_status_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
